// File: rtl/motor_pkg.sv
// Shared encodings for the motor command sequencer: FSM states, MotorDriver
// direction codes and the normalised target record.
package motor_pkg;

    localparam int SPD_W = 2;

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] DIR_BRAKE = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;

    typedef struct packed {
        logic [1:0]       dir;
        logic [SPD_W-1:0] spd;
    } motor_tgt_t;

    // Any brake code or a zero gear collapses to the single brake target.
    function automatic motor_tgt_t norm_cmd(input logic [1:0]       dir,
                                            input logic [SPD_W-1:0] spd);
        motor_tgt_t t;
        if ((dir == DIR_FWD || dir == DIR_REV) && spd != '0) begin
            t.dir = dir;
            t.spd = spd;
        end else begin
            t.dir = DIR_BRAKE;
            t.spd = '0;
        end
        return t;
    endfunction

endpackage

// File: rtl/motor_tick_timer.sv
// Shared tick counter for ramp steps and brake dead-time. Counts while enabled,
// flags the terminal count (limit-1) and restarts from zero after it.
module motor_tick_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [TW-1:0] i_limit,
    output logic          o_tc
);

    logic [TW-1:0] r_cnt;

    // >= rather than == so a limit change mid-count can never let it wrap.
    assign o_tc = (r_cnt >= i_limit - TW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Command sequencer in front of MotorDriver: ramps speed one gear per
// RAMP_TICKS, brakes for DEAD_TICKS across a reversal, estop overrides all.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int RAMP_TICKS = 1000,
    parameter int DEAD_TICKS = 500,
    parameter int TW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             estop,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_dir,
    input  logic [SPD_W-1:0] cmd_speed,
    output logic             cmd_ready,
    output logic [1:0]       choose,
    output logic [SPD_W-1:0] speed,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    logic [1:0]       r_state;
    logic [1:0]       r_cur_dir;
    logic [SPD_W-1:0] r_cur_spd;
    motor_tgt_t       r_tgt;
    logic             r_done;

    logic             w_accept;
    motor_tgt_t       w_cmd;
    logic [SPD_W-1:0] w_goal;
    logic [SPD_W-1:0] w_spd_step;
    logic             w_tc;
    logic             w_tmr_en;
    logic             w_tmr_clr;
    logic [TW-1:0]    w_limit;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_cur_dir_nxt;
    logic [SPD_W-1:0] w_cur_spd_nxt;
    motor_tgt_t       w_tgt_nxt;
    logic             w_done_nxt;

    assign cmd_ready = (r_state == ST_STOP || r_state == ST_HOLD) && !estop;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cmd     = norm_cmd(cmd_dir, cmd_speed);

    // Opposite-direction targets ramp down to zero before anything else.
    assign w_goal = (r_tgt.dir == r_cur_dir) ? r_tgt.spd : '0;

    always_comb begin
        w_spd_step = r_cur_spd;
        if (w_tc) begin
            if (r_cur_spd < w_goal)
                w_spd_step = r_cur_spd + SPD_W'(1);
            else if (r_cur_spd > w_goal)
                w_spd_step = r_cur_spd - SPD_W'(1);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cur_dir_nxt = r_cur_dir;
        w_cur_spd_nxt = r_cur_spd;
        w_tgt_nxt     = r_tgt;
        w_done_nxt    = 1'b0;

        if (estop) begin
            w_state_nxt   = ST_STOP;
            w_cur_dir_nxt = DIR_BRAKE;
            w_cur_spd_nxt = '0;
            w_tgt_nxt     = '{dir: DIR_BRAKE, spd: '0};
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (w_accept) begin
                        w_tgt_nxt = w_cmd;
                        if (w_cmd.dir != DIR_BRAKE) begin
                            w_cur_dir_nxt = w_cmd.dir;
                            w_state_nxt   = ST_RAMP;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_accept && w_cmd != r_tgt) begin
                        w_tgt_nxt   = w_cmd;
                        w_state_nxt = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Exit checks run every cycle on the post-step speed, which
                    // also covers entering RAMP already at the goal.
                    w_cur_spd_nxt = w_spd_step;
                    if (w_spd_step == w_goal && w_goal != '0) begin
                        w_state_nxt = ST_HOLD;
                        w_done_nxt  = 1'b1;
                    end else if (w_spd_step == '0 && r_tgt.dir == DIR_BRAKE) begin
                        w_state_nxt   = ST_STOP;
                        w_cur_dir_nxt = DIR_BRAKE;
                        w_done_nxt    = 1'b1;
                    end else if (w_spd_step == '0 && r_tgt.dir != r_cur_dir) begin
                        w_state_nxt = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (w_tc) begin
                        w_cur_dir_nxt = r_tgt.dir;
                        w_state_nxt   = ST_RAMP;
                    end
                end
                default: w_state_nxt = ST_STOP;
            endcase
        end
    end

    // Every state change restarts the timer so each phase counts from zero.
    assign w_tmr_en  = (r_state == ST_RAMP) || (r_state == ST_DEAD);
    assign w_tmr_clr = estop || (w_state_nxt != r_state);
    assign w_limit   = (r_state == ST_DEAD) ? TW'(DEAD_TICKS) : TW'(RAMP_TICKS);

    motor_tick_timer #(
        .TW (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_STOP;
            r_cur_dir <= DIR_BRAKE;
            r_cur_spd <= '0;
            r_tgt     <= '{dir: DIR_BRAKE, spd: '0};
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_dir <= w_cur_dir_nxt;
            r_cur_spd <= w_cur_spd_nxt;
            r_tgt     <= w_tgt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign choose = (r_cur_spd == '0) ? DIR_BRAKE : r_cur_dir;
    assign speed  = r_cur_spd;
    assign busy   = (r_state == ST_RAMP) || (r_state == ST_DEAD);
    assign done   = r_done;
    assign state  = r_state;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed vector bench for motor_ramp_ctrl with RAMP_TICKS=4, DEAD_TICKS=3.
module tb_motor_ramp_ctrl;
    import motor_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dir = 2'b00;
    logic [1:0] cmd_speed = 2'd0;
    logic       cmd_ready, busy, done;
    logic [1:0] choose, speed, state;

    int nvec = 0;
    int nfail = 0;
    int done_cnt = 0;
    int dead_cnt = 0;
    int notfwd_cnt = 0;

    motor_ramp_ctrl #(.RAMP_TICKS(4), .DEAD_TICKS(3), .TW(8)) dut (
        .clk(clk), .rst(rst), .estop(estop), .cmd_valid(cmd_valid),
        .cmd_dir(cmd_dir), .cmd_speed(cmd_speed), .cmd_ready(cmd_ready),
        .choose(choose), .speed(speed), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (state == ST_DEAD) dead_cnt++;
        if (choose != DIR_FWD) notfwd_cnt++;
    end

    typedef struct {
        logic rn; logic es; logic vl; logic [1:0] dir; logic [1:0] spd; int n;
        logic [1:0] ch; logic [1:0] sp; logic [1:0] st; logic dn; logic bz; logic rd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rn, logic es, logic vl, logic [1:0] dir, logic [1:0] spd,
                                int n, logic [1:0] ch, logic [1:0] sp, logic [1:0] st,
                                logic dn, logic bz, logic rd);
        vec_t v;
        v.rn = rn; v.es = es; v.vl = vl; v.dir = dir; v.spd = spd; v.n = n;
        v.ch = ch; v.sp = sp; v.st = st; v.dn = dn; v.bz = bz; v.rd = rd;
        return v;
    endfunction

    // Inputs are held for one edge, then idle for the remaining n-1 edges.
    task automatic drive(input logic rn, input logic es, input logic vl,
                         input logic [1:0] dir, input logic [1:0] spd, input int n);
        rst = rn; estop = es; cmd_valid = vl; cmd_dir = dir; cmd_speed = spd;
        @(posedge clk); #1;
        rst = 1'b1; estop = 1'b0; cmd_valid = 1'b0; cmd_dir = 2'b00; cmd_speed = 2'd0;
        repeat (n - 1) begin @(posedge clk); #1; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string nm, input logic [1:0] ch, input logic [1:0] sp,
                       input logic [1:0] st, input logic dn, input logic bz, input logic rd);
        nvec++;
        if ({choose, speed, state, done, busy, cmd_ready} !== {ch, sp, st, dn, bz, rd}) begin
            nfail++;
            $display("FAIL %s: got ch=%b sp=%0d st=%0d dn=%b bz=%b rd=%b, want ch=%b sp=%0d st=%0d dn=%b bz=%b rd=%b",
                     nm, choose, speed, state, done, busy, cmd_ready, ch, sp, st, dn, bz, rd);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    int d0, dd0, nf0;

    initial begin
        // reset, forward ramp 0->3
        tv.push_back(mk(L,L,L,DIR_BRAKE,2'd0,1, DIR_BRAKE,2'd0,ST_STOP,L,L,H));
        tv.push_back(mk(H,L,H,DIR_FWD,  2'd3,1, DIR_BRAKE,2'd0,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,3, DIR_BRAKE,2'd0,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,1, DIR_FWD,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd2,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd3,ST_HOLD,H,L,H));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,1, DIR_FWD,  2'd3,ST_HOLD,L,L,H));
        // same-direction slow-down 3->1, then up to 2
        tv.push_back(mk(H,L,H,DIR_FWD,  2'd1,1, DIR_FWD,  2'd3,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd2,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd1,ST_HOLD,H,L,H));
        tv.push_back(mk(H,L,H,DIR_FWD,  2'd2,1, DIR_FWD,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd2,ST_HOLD,H,L,H));
        // reversal 01/2 -> 10/1 through dead-time
        tv.push_back(mk(H,L,H,DIR_REV,  2'd1,1, DIR_FWD,  2'd2,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_BRAKE,2'd0,ST_DEAD,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,2, DIR_BRAKE,2'd0,ST_DEAD,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,1, DIR_BRAKE,2'd0,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,3, DIR_BRAKE,2'd0,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,1, DIR_REV,  2'd1,ST_HOLD,H,L,H));
        // brake from 10/2, repeated brake and non-moving commands in STOP
        tv.push_back(mk(H,L,H,DIR_REV,  2'd2,1, DIR_REV,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_REV,  2'd2,ST_HOLD,H,L,H));
        tv.push_back(mk(H,L,H,DIR_BRAKE,2'd3,1, DIR_REV,  2'd2,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_REV,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_BRAKE,2'd0,ST_STOP,H,L,H));
        tv.push_back(mk(H,L,H,DIR_BRAKE,2'd3,1, DIR_BRAKE,2'd0,ST_STOP,L,L,H));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,1, DIR_BRAKE,2'd0,ST_STOP,L,L,H));
        tv.push_back(mk(H,L,H,2'b11,    2'd2,1, DIR_BRAKE,2'd0,ST_STOP,L,L,H));
        tv.push_back(mk(H,L,H,DIR_FWD,  2'd0,1, DIR_BRAKE,2'd0,ST_STOP,L,L,H));
        // HOLD with identical command stays put
        tv.push_back(mk(H,L,H,DIR_REV,  2'd1,1, DIR_BRAKE,2'd0,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_REV,  2'd1,ST_HOLD,H,L,H));
        tv.push_back(mk(H,L,H,DIR_REV,  2'd1,1, DIR_REV,  2'd1,ST_HOLD,L,L,H));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,5, DIR_REV,  2'd1,ST_HOLD,L,L,H));
        // command presented during RAMP is ignored
        tv.push_back(mk(H,L,H,DIR_FWD,  2'd3,1, DIR_REV,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,H,DIR_REV,  2'd3,1, DIR_REV,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,3, DIR_BRAKE,2'd0,ST_DEAD,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,3, DIR_BRAKE,2'd0,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd1,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd2,ST_RAMP,L,H,L));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,4, DIR_FWD,  2'd3,ST_HOLD,H,L,H));
        tv.push_back(mk(H,L,L,DIR_BRAKE,2'd0,1, DIR_FWD,  2'd3,ST_HOLD,L,L,H));

        foreach (tv[i]) begin
            drive(tv[i].rn, tv[i].es, tv[i].vl, tv[i].dir, tv[i].spd, tv[i].n);
            chk($sformatf("vec%0d", i), tv[i].ch, tv[i].sp, tv[i].st, tv[i].dn, tv[i].bz, tv[i].rd);
        end

        // estop mid-ramp at speed 2
        drive(L, L, L, DIR_BRAKE, 2'd0, 1);
        drive(H, L, H, DIR_FWD, 2'd3, 1);
        idle(8);
        chk("estop_pre", DIR_FWD, 2'd2, ST_RAMP, L, H, L);
        d0 = done_cnt;
        estop = 1'b1;
        @(posedge clk); #1;
        chk("estop_hit", DIR_BRAKE, 2'd0, ST_STOP, L, L, L);
        estop = 1'b0;
        #1;
        chk("estop_rel", DIR_BRAKE, 2'd0, ST_STOP, L, L, H);
        idle(3);
        chk("estop_stay", DIR_BRAKE, 2'd0, ST_STOP, L, L, H);
        chk_int("estop_no_done", done_cnt - d0, 0);
        drive(H, L, H, DIR_FWD, 2'd1, 1);
        idle(4);
        chk("estop_after", DIR_FWD, 2'd1, ST_HOLD, H, L, H);

        // slow-down 3->1 never leaves forward and never brakes
        drive(H, L, H, DIR_FWD, 2'd3, 1);
        idle(8);
        chk("slow_pre", DIR_FWD, 2'd3, ST_HOLD, H, L, H);
        idle(1);
        d0 = done_cnt; dd0 = dead_cnt; nf0 = notfwd_cnt;
        drive(H, L, H, DIR_FWD, 2'd1, 1);
        idle(8);
        chk("slow_end", DIR_FWD, 2'd1, ST_HOLD, H, L, H);
        idle(1);
        chk_int("slow_done_cnt", done_cnt - d0, 1);
        chk_int("slow_dead_cnt", dead_cnt - dd0, 0);
        chk_int("slow_choose", notfwd_cnt - nf0, 0);

        // reset while in DEAD, with a command and estop-free inputs present
        drive(H, L, H, DIR_REV, 2'd1, 1);
        idle(4);
        chk("rst_dead_pre", DIR_BRAKE, 2'd0, ST_DEAD, L, H, L);
        idle(1);
        drive(L, L, H, DIR_FWD, 2'd2, 1);
        chk("rst_dead", DIR_BRAKE, 2'd0, ST_STOP, L, L, H);
        drive(H, L, H, DIR_FWD, 2'd2, 1);
        chk("rst_cmd", DIR_BRAKE, 2'd0, ST_RAMP, L, H, L);
        idle(4);
        chk("rst_ramp1", DIR_FWD, 2'd1, ST_RAMP, L, H, L);
        idle(4);
        chk("rst_ramp2", DIR_FWD, 2'd2, ST_HOLD, H, L, H);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
